// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot sequencer between the instruction-stream loader and the
// instruction memory. Loads the first WORD_COUNT words, optionally verifies them
// with a read-back checksum, then hands the read port to CPU fetch and releases
// the CPU from reset.
// Optional feature macro: IMEM_BOOT_VERIFY_EN (adds VERIFY/ERROR states and the
// read-back checksum gate on CPU release).
module imem_boot_ctrl #(
  parameter int unsigned WORD_COUNT = 44,
  parameter int unsigned IMEM_AW    = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [31:0]        i_ld_data,
  input  logic [31:0]        i_ld_address,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  input  logic               i_reload,
  input  logic [31:0]        i_cpu_fetch_addr,
  output logic [31:0]        o_cpu_instr,
  output logic               o_cpu_reset,
  output logic               o_imem_we,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [31:0]        o_imem_wdata,
  input  logic [31:0]        i_imem_rdata,
  output logic               o_load_done,
  output logic               o_load_error
);

  localparam int unsigned     CNT_W    = $clog2(WORD_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_COUNT - 1);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd2;
`ifdef IMEM_BOOT_VERIFY_EN
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WORD_COUNT);
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             w_accept;
  logic             w_restart;
`ifdef IMEM_BOOT_VERIFY_EN
  logic [CNT_W-1:0] r_rd_cnt;
  logic [31:0]      r_sum;
  logic [31:0]      r_chk;
  logic [31:0]      w_chk_final;
`endif

  // Fetch address bits outside the word index are intentionally ignored.
  logic w_unused_fetch_bits;
  assign w_unused_fetch_bits = ^{i_cpu_fetch_addr[31:IMEM_AW+2], i_cpu_fetch_addr[1:0]};

  // Reset and reload both restart the boot sequence; the read port data goes straight to the CPU.
  assign w_restart   = i_reset | i_reload;
  assign o_cpu_instr = i_imem_rdata;
`ifdef IMEM_BOOT_VERIFY_EN
  assign w_chk_final = r_chk + i_imem_rdata;
`endif

  // Next-state and output decode; memory write path is combinational so the
  // accepted word lands on the same edge it is accepted.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    o_ld_ready   = 1'b0;
    o_cpu_reset  = 1'b1;
    o_load_done  = 1'b0;
    o_load_error = 1'b0;
    o_imem_we    = 1'b0;
    o_imem_addr  = IMEM_AW'(r_wr_cnt);
    o_imem_wdata = i_ld_data;
    case (r_state)
      ST_LOAD: begin
        o_ld_ready = 1'b1;
        w_accept   = i_ld_valid && (i_ld_address == 32'(r_wr_cnt)) && !w_restart;
        o_imem_we  = w_accept;
        if (w_accept && (r_wr_cnt == LAST_IDX)) begin
`ifdef IMEM_BOOT_VERIFY_EN
          w_state_nxt = ST_VERIFY;
`else
          w_state_nxt = ST_RUN;
`endif
        end
      end
`ifdef IMEM_BOOT_VERIFY_EN
      ST_VERIFY: begin
        o_imem_addr = IMEM_AW'(r_rd_cnt);
        if (r_rd_cnt == CNT_END) begin
          w_state_nxt = (w_chk_final == r_sum) ? ST_RUN : ST_ERROR;
        end
      end
      ST_ERROR: begin
        o_load_error = 1'b1;
      end
`endif
      ST_RUN: begin
        o_cpu_reset = 1'b0;
        o_load_done = 1'b1;
        o_imem_addr = i_cpu_fetch_addr[IMEM_AW+1:2];
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
    if (w_restart) begin
      w_state_nxt = ST_LOAD;
    end
  end

  // State register plus load/verify counters and checksums.
  always_ff @(posedge i_clock) begin
    if (w_restart) begin
      r_state  <= ST_LOAD;
      r_wr_cnt <= '0;
`ifdef IMEM_BOOT_VERIFY_EN
      r_rd_cnt <= '0;
      r_sum    <= '0;
      r_chk    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
`ifdef IMEM_BOOT_VERIFY_EN
        r_sum    <= r_sum + i_ld_data;
`endif
      end
`ifdef IMEM_BOOT_VERIFY_EN
      if (r_state == ST_VERIFY) begin
        // Read data trails the issued address by one cycle.
        if (r_rd_cnt != '0) begin
          r_chk <= w_chk_final;
        end
        if (r_rd_cnt != CNT_END) begin
          r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl with a synchronous-read memory model.
`timescale 1ns/1ps
module tb_imem_boot_ctrl;

  localparam int unsigned WC = 44;
  localparam int unsigned AW = 6;
`ifdef IMEM_BOOT_VERIFY_EN
  localparam int LAT = WC + 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [31:0]   i_ld_data = '0;
  logic [31:0]   i_ld_address = '0;
  logic          i_ld_valid = 1'b0;
  logic          o_ld_ready;
  logic          i_reload = 1'b0;
  logic [31:0]   i_cpu_fetch_addr = '0;
  logic [31:0]   o_cpu_instr;
  logic          o_cpu_reset;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic [31:0]   i_imem_rdata;
  logic          o_load_done;
  logic          o_load_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.WORD_COUNT(WC), .IMEM_AW(AW)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_ld_data(i_ld_data), .i_ld_address(i_ld_address),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_reload(i_reload),
    .i_cpu_fetch_addr(i_cpu_fetch_addr), .o_cpu_instr(o_cpu_instr), .o_cpu_reset(o_cpu_reset),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .i_imem_rdata(i_imem_rdata), .o_load_done(o_load_done), .o_load_error(o_load_error)
  );

  // Memory model: synchronous read, optional bit-0 corruption of word 7.
  logic [31:0] mem [0:63];
  bit corrupt = 1'b0;
  always @(posedge clk) begin
    if (o_imem_we === 1'b1)
      mem[o_imem_addr] <= (corrupt && o_imem_addr == AW'(7)) ? (o_imem_wdata ^ 32'h1) : o_imem_wdata;
    i_imem_rdata <= mem[o_imem_addr];
  end

  // Observation log: writes seen and cycles of release / error entry.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int last_we_cyc = -1, rel_cyc = -1, err_cyc = -1;
  logic [AW-1:0] act_a [$];
  logic [31:0]   act_d [$];
  logic prev_rst = 1'b1, prev_err = 1'b0;
  always @(negedge clk) begin
    if (o_imem_we === 1'b1) begin
      act_a.push_back(o_imem_addr);
      act_d.push_back(o_imem_wdata);
      last_we_cyc = cyc;
    end
    if (prev_rst === 1'b1 && o_cpu_reset === 1'b0) rel_cyc = cyc;
    if (prev_err === 1'b0 && o_load_error === 1'b1) err_cyc = cyc;
    prev_rst = o_cpu_reset;
    prev_err = o_load_error;
  end

  // Reference model: the image the loader is expected to leave in memory.
  int            m_wr = 0;
  bit            m_loading = 1'b1;
  logic [AW-1:0] exp_a [$];
  logic [31:0]   exp_d [$];
  logic [31:0]   m_img [0:WC-1];
  logic [31:0]   wd [0:63];

  task automatic clear_logs();
    act_a.delete(); act_d.delete(); exp_a.delete(); exp_d.delete();
    rel_cyc = -1; err_cyc = -1;
  endtask

  task automatic new_words();
    for (int i = 0; i < 64; i++) wd[i] = $urandom;
  endtask

  // One loader cycle; the model predicts whether it produces a write.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic rl, input logic rs);
    i_ld_valid = v; i_ld_address = a; i_ld_data = d; i_reload = rl; i_reset = rs;
    if (rl || rs) begin
      m_wr = 0; m_loading = 1'b1;
    end else if (v && m_loading && a == 32'(m_wr)) begin
      exp_a.push_back(AW'(m_wr)); exp_d.push_back(d);
      m_img[m_wr] = d;
      m_wr++;
      if (m_wr == int'(WC)) m_loading = 1'b0;
    end
    @(posedge clk); #1;
    i_ld_valid = 1'b0; i_reload = 1'b0; i_reset = 1'b0;
  endtask

  task automatic stream(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) drive(1'b1, 32'(a), wd[a], 1'b0, 1'b0);
  endtask

  task automatic wait_boot(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (o_load_done === 1'b1 || o_load_error === 1'b1) begin ok = 1'b1; break; end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_ld_valid = 1'b1; i_ld_address = '0; i_ld_data = $urandom;
    @(negedge clk);
    checks++; if (o_imem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", o_imem_we); end
    checks++; if (o_cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b want 1", o_cpu_reset); end
    checks++; if (o_load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done got %b want 0", o_load_done); end
    checks++; if (o_load_error !== 1'b0) begin errors++; $display("FAIL rst_load_error got %b want 0", o_load_error); end
    checks++; if (o_ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready got %b want 1", o_ld_ready); end
    @(posedge clk); #1;
    i_reset = 1'b0; i_ld_valid = 1'b0;
    m_wr = 0; m_loading = 1'b1;
    clear_logs();
  endtask

  task automatic test_full_boot();
    bit ok;
    new_words();
    stream(0, 63);
    wait_boot(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout got 0 want 1"); end
    checks++; if (act_a.size() != int'(WC)) begin errors++; $display("FAIL full_wr_count got %0d want %0d", act_a.size(), WC); end
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      checks++;
      if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL full_write[%0d] got %0d:%h want %0d:%h", i, act_a[i], act_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (rel_cyc - last_we_cyc != LAT) begin errors++; $display("FAIL full_release_lat got %0d want %0d", rel_cyc - last_we_cyc, LAT); end
    checks++; if (o_load_done !== 1'b1 || o_cpu_reset !== 1'b0) begin errors++; $display("FAIL full_run got done=%b rst=%b want 1/0", o_load_done, o_cpu_reset); end
    checks++; if (o_ld_ready !== 1'b0 || o_load_error !== 1'b0) begin errors++; $display("FAIL full_run_flags got rdy=%b err=%b want 0/0", o_ld_ready, o_load_error); end
    for (int i = 0; i < int'(WC); i++) begin
      checks++; if (mem[i] !== m_img[i]) begin errors++; $display("FAIL full_mem[%0d] got %h want %h", i, mem[i], m_img[i]); end
    end
  endtask

  task automatic test_fetch();
    int idx;
    clear_logs();
    i_cpu_fetch_addr = 32'h0000_0010; i_ld_valid = 1'b1; i_ld_address = '0; i_ld_data = $urandom;
    @(negedge clk);
    checks++; if (o_imem_addr !== AW'(4)) begin errors++; $display("FAIL fetch_addr got %0d want 4", o_imem_addr); end
    checks++; if (o_imem_we !== 1'b0) begin errors++; $display("FAIL fetch_we got %b want 0", o_imem_we); end
    @(posedge clk); #1;
    i_ld_address = 32'd4;
    @(negedge clk);
    checks++; if (o_cpu_instr !== m_img[4]) begin errors++; $display("FAIL fetch_instr4 got %h want %h", o_cpu_instr, m_img[4]); end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      idx = $urandom_range(0, WC - 1);
      i_cpu_fetch_addr = ($urandom & 32'hFFFF_FF03) | (32'(idx) << 2);
      i_ld_valid = 1'($urandom); i_ld_address = 32'($urandom_range(0, 63)); i_ld_data = $urandom;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (o_cpu_instr !== m_img[idx]) begin errors++; $display("FAIL fetch_rand[%0d] got %h want %h", idx, o_cpu_instr, m_img[idx]); end
    end
    @(posedge clk); #1;
    i_ld_valid = 1'b0;
    @(negedge clk);
    checks++; if (act_a.size() != 0) begin errors++; $display("FAIL fetch_no_writes got %0d want 0", act_a.size()); end
  endtask

  task automatic test_mid_start();
    bit ok;
    clear_logs();
    new_words();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (o_cpu_reset !== 1'b1 || o_ld_ready !== 1'b1 || o_load_done !== 1'b0) begin
      errors++; $display("FAIL mid_reload got rst=%b rdy=%b done=%b want 1/1/0", o_cpu_reset, o_ld_ready, o_load_done); end
    for (int a = 20; a <= 63; a++) drive(1'b1, 32'(a), $urandom, 1'b0, 1'b0);
    checks++; if (act_a.size() != 0) begin errors++; $display("FAIL mid_no_early_writes got %0d want 0", act_a.size()); end
    stream(0, 63);
    wait_boot(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got 0 want 1"); end
    checks++; if (act_a.size() != exp_a.size()) begin errors++; $display("FAIL mid_wr_count got %0d want %0d", act_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      checks++;
      if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL mid_write[%0d] got %0d:%h want %0d:%h", i, act_a[i], act_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (rel_cyc - last_we_cyc != LAT) begin errors++; $display("FAIL mid_release_lat got %0d want %0d", rel_cyc - last_we_cyc, LAT); end
    for (int i = 0; i < int'(WC); i++) begin
      checks++; if (mem[i] !== wd[i]) begin errors++; $display("FAIL mid_mem[%0d] got %h want %h", i, mem[i], wd[i]); end
    end
  endtask

  task automatic test_reload();
    bit ok;
    clear_logs();
    new_words();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    stream(0, 29);
    // Reload coincident with a word that would otherwise be accepted.
    i_ld_valid = 1'b1; i_ld_address = 32'd30; i_ld_data = wd[30]; i_reload = 1'b1;
    m_wr = 0; m_loading = 1'b1;
    @(negedge clk);
    checks++; if (o_imem_we !== 1'b0) begin errors++; $display("FAIL reload_accept_we got %b want 0", o_imem_we); end
    @(posedge clk); #1;
    i_reload = 1'b0; i_ld_valid = 1'b0;
    @(negedge clk);
    checks++; if (o_cpu_reset !== 1'b1 || o_ld_ready !== 1'b1) begin errors++; $display("FAIL reload_state got rst=%b rdy=%b want 1/1", o_cpu_reset, o_ld_ready); end
    drive(1'b1, 32'd30, wd[30], 1'b0, 1'b0);
    drive(1'b1, 32'd1, wd[1], 1'b0, 1'b0);
    checks++; if (act_a.size() != 30) begin errors++; $display("FAIL reload_resync got %0d want 30", act_a.size()); end
    stream(0, 63);
    wait_boot(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reload_timeout got 0 want 1"); end
    checks++; if (act_a.size() != exp_a.size()) begin errors++; $display("FAIL reload_wr_count got %0d want %0d", act_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      checks++;
      if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL reload_write[%0d] got %0d:%h want %0d:%h", i, act_a[i], act_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (rel_cyc - last_we_cyc != LAT) begin errors++; $display("FAIL reload_release_lat got %0d want %0d", rel_cyc - last_we_cyc, LAT); end
    for (int i = 0; i < int'(WC); i++) begin
      checks++; if (mem[i] !== m_img[i]) begin errors++; $display("FAIL reload_mem[%0d] got %h want %h", i, mem[i], m_img[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    new_words();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    stream(0, 9);
    drive(1'b1, 32'd10, wd[10], 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (o_cpu_reset !== 1'b1 || o_load_done !== 1'b0 || o_load_error !== 1'b0 || o_imem_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_load got rst=%b done=%b err=%b we=%b want 1/0/0/0", o_cpu_reset, o_load_done, o_load_error, o_imem_we); end
    checks++; if (act_a.size() != 10) begin errors++; $display("FAIL rstmid_load_writes got %0d want 10", act_a.size()); end
`ifdef IMEM_BOOT_VERIFY_EN
    stream(0, 43);
    repeat (10) drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (o_cpu_reset !== 1'b1 || o_load_done !== 1'b0 || o_load_error !== 1'b0 || o_imem_we !== 1'b0 || o_ld_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_verify got rst=%b done=%b err=%b we=%b rdy=%b want 1/0/0/0/1", o_cpu_reset, o_load_done, o_load_error, o_imem_we, o_ld_ready); end
`endif
    rel_cyc = -1;
    stream(0, 63);
    wait_boot(ok);
    checks++; if (!ok || o_load_done !== 1'b1) begin errors++; $display("FAIL rstmid_boot got done=%b want 1", o_load_done); end
    checks++; if (act_a.size() != exp_a.size()) begin errors++; $display("FAIL rstmid_wr_count got %0d want %0d", act_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      checks++;
      if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL rstmid_write[%0d] got %0d:%h want %0d:%h", i, act_a[i], act_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (rel_cyc - last_we_cyc != LAT) begin errors++; $display("FAIL rstmid_release_lat got %0d want %0d", rel_cyc - last_we_cyc, LAT); end
    for (int i = 0; i < int'(WC); i++) begin
      checks++; if (mem[i] !== m_img[i]) begin errors++; $display("FAIL rstmid_mem[%0d] got %h want %h", i, mem[i], m_img[i]); end
    end
  endtask

`ifdef IMEM_BOOT_VERIFY_EN
  task automatic test_error();
    bit ok;
    clear_logs();
    new_words();
    corrupt = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    stream(0, 63);
    wait_boot(ok);
    checks++; if (!ok || o_load_error !== 1'b1) begin errors++; $display("FAIL err_entered got %b want 1", o_load_error); end
    checks++; if (o_cpu_reset !== 1'b1 || o_load_done !== 1'b0 || o_ld_ready !== 1'b0) begin
      errors++; $display("FAIL err_flags got rst=%b done=%b rdy=%b want 1/0/0", o_cpu_reset, o_load_done, o_ld_ready); end
    checks++; if (err_cyc - last_we_cyc != LAT) begin errors++; $display("FAIL err_lat got %0d want %0d", err_cyc - last_we_cyc, LAT); end
    repeat (3) drive(1'b1, '0, wd[0], 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (o_load_error !== 1'b1 || o_cpu_reset !== 1'b1) begin errors++; $display("FAIL err_hold got err=%b rst=%b want 1/1", o_load_error, o_cpu_reset); end
    checks++; if (act_a.size() != int'(WC)) begin errors++; $display("FAIL err_wr_count got %0d want %0d", act_a.size(), WC); end
    corrupt = 1'b0;
    clear_logs();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (o_load_error !== 1'b0 || o_ld_ready !== 1'b1 || o_cpu_reset !== 1'b1) begin
      errors++; $display("FAIL err_reload got err=%b rdy=%b rst=%b want 0/1/1", o_load_error, o_ld_ready, o_cpu_reset); end
    stream(0, 63);
    wait_boot(ok);
    checks++; if (!ok || o_load_done !== 1'b1 || o_load_error !== 1'b0) begin
      errors++; $display("FAIL err_clean_boot got done=%b err=%b want 1/0", o_load_done, o_load_error); end
    checks++; if (rel_cyc - last_we_cyc != LAT) begin errors++; $display("FAIL err_clean_lat got %0d want %0d", rel_cyc - last_we_cyc, LAT); end
    for (int i = 0; i < int'(WC); i++) begin
      checks++; if (mem[i] !== m_img[i]) begin errors++; $display("FAIL err_mem[%0d] got %h want %h", i, mem[i], m_img[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_boot();
    test_fetch();
    test_mid_start();
    test_reload();
    test_reset_mid();
`ifdef IMEM_BOOT_VERIFY_EN
    test_error();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
